// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    MULT  = 2'd1,
    DIVU  = 2'd2,
    DIV   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);

  function automatic logic isDivOp(input op_t o);
    return (o == DIVU) || (o == DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide unit signal bundle (operands, MTHI/MTLO, HI/LO).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             hiwe;
  logic             lowe;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, cancel, hiwe, lowe, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, cancel, hiwe, lowe, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on operand magnitudes for 32 cycles, then fixes signs and commits.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  state_t             state;
  state_t             nextState;
  logic [CNT_W-1:0]   count;
  op_t                opReg;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] stepNext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic               opSigned;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hiFix;
  logic [WIDTH-1:0]   loFix;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (bus.start && !bus.cancel) nextState = CALC;
      CALC: begin
        if (bus.cancel)                         nextState = IDLE;
        else if (count == CNT_W'(ITERS - 1))    nextState = FIX;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = doneReg;
    bus.hi   = hiReg;
    bus.lo   = loReg;
  end

  // Launch-time magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
  always_comb begin
    opSigned = (bus.op == MULT) || (bus.op == DIV);
    negA     = opSigned && bus.srca[WIDTH-1];
    negB     = opSigned && bus.srcb[WIDTH-1];
    absA     = negA ? -bus.srca : bus.srca;
    absB     = negB ? -bus.srcb : bus.srcb;
  end

  // One iteration. Multiply: work = {acc, multiplier}, shift right with add.
  // Divide: work = {remainder, dividend/quotient}; bit WIDTH of the 33-bit
  // difference is the borrow, i.e. the restore decision.
  always_comb begin
    mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, magA};
    divShift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    divDiff  = divShift - {1'b0, magB};
    if (isDivOp(opReg)) begin
      if (divDiff[WIDTH]) stepNext = {divShift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      else                stepNext = {divDiff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
    end else begin
      if (work[0]) stepNext = {mulSum, work[WIDTH-1:1]};
      else         stepNext = {1'b0, work[2*WIDTH-1:WIDTH], work[WIDTH-1:1]};
    end
  end

  always_comb begin
    product = (signA ^ signB) ? -work : work;
    quot    = (signA ^ signB) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem     = signA ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    if (isDivOp(opReg)) begin
      hiFix = rem;
      loFix = (magB == '0) ? '1 : quot;
    end else begin
      hiFix = product[2*WIDTH-1:WIDTH];
      loFix = product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      opReg   <= MULTU;
      signA   <= 1'b0;
      signB   <= 1'b0;
      magA    <= '0;
      magB    <= '0;
      work    <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hiwe) hiReg <= bus.wd;
          if (bus.lowe) loReg <= bus.wd;
          if (bus.start && !bus.cancel) begin
            opReg <= bus.op;
            signA <= negA;
            signB <= negB;
            magA  <= absA;
            magB  <= absB;
            count <= '0;
            work  <= isDivOp(bus.op) ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            work  <= stepNext;
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            hiReg   <= hiFix;
            loReg   <= loFix;
            doneReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Bench for muldiv: fixed vectors, directed handshake sequences, and random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void refModel(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    logic [63:0]        p;
    sa = a;
    sb = b;
    pa = sa;
    pb = sb;
    h = '0;
    l = '0;
    case (op)
      MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      MULT: begin
        p = pa * pb;
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (op == DIVU) begin
          l = a / b;
          h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 10));
      4:       return -32'($urandom_range(1, 10));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic doOp(input op_t op, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int busyCnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
    check("done low after launch", 32'(bus.done), 32'd0);
    lat     = 1;
    busyCnt = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
    check("done arrives (timeout)", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int          lat;
    int          busyCnt;
    int          seen;
    logic [31:0] eh;
    logic [31:0] el;
    op_t         rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{name:"MULTU ffffffff*ffffffff", op:MULTU, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, expHi:32'hFFFF_FFFE, expLo:32'h0000_0001};
    vecs[1] = '{name:"MULT -3*5",               op:MULT,  a:32'hFFFF_FFFD, b:32'd5,         expHi:32'hFFFF_FFFF, expLo:32'hFFFF_FFF1};
    vecs[2] = '{name:"MULT 80000000^2",         op:MULT,  a:32'h8000_0000, b:32'h8000_0000, expHi:32'h4000_0000, expLo:32'h0000_0000};
    vecs[3] = '{name:"DIV -7/2",                op:DIV,   a:32'hFFFF_FFF9, b:32'd2,         expHi:32'hFFFF_FFFF, expLo:32'hFFFF_FFFD};
    vecs[4] = '{name:"DIVU 7/2",                op:DIVU,  a:32'd7,         b:32'd2,         expHi:32'd1,         expLo:32'd3};
    vecs[5] = '{name:"DIVU 1234/0",             op:DIVU,  a:32'h1234,      b:32'd0,         expHi:32'h1234,      expLo:32'hFFFF_FFFF};
    vecs[6] = '{name:"DIV 80000000/-1",         op:DIV,   a:32'h8000_0000, b:32'hFFFF_FFFF, expHi:32'd0,         expLo:32'h8000_0000};
    vecs[7] = '{name:"DIV -7/-2",               op:DIV,   a:32'hFFFF_FFF9, b:32'hFFFF_FFFE, expHi:32'hFFFF_FFFF, expLo:32'd3};
    vecs[8] = '{name:"DIV 7/-2",                op:DIV,   a:32'd7,         b:32'hFFFF_FFFE, expHi:32'd1,         expLo:32'hFFFF_FFFD};
    vecs[9] = '{name:"DIV -8/0",                op:DIV,   a:32'hFFFF_FFF8, b:32'd0,         expHi:32'hFFFF_FFF8, expLo:32'hFFFF_FFFF};

    bus.start  = 1'b0;
    bus.op     = MULTU;
    bus.srca   = '0;
    bus.srcb   = '0;
    bus.cancel = 1'b0;
    bus.hiwe   = 1'b0;
    bus.lowe   = 1'b0;
    bus.wd     = '0;

    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO in IDLE
    bus.hiwe = 1'b1;
    bus.wd   = 32'h0000_AAAA;
    @(negedge clk);
    bus.hiwe = 1'b0;
    check("MTHI hi", bus.hi, 32'h0000_AAAA);
    check("MTHI lo untouched", bus.lo, 32'd0);

    // hiwe while busy is ignored (op cancelled so HI keeps its prior value)
    bus.op   = MULTU;
    bus.srca = 32'd3;
    bus.srcb = 32'd4;
    bus.wd   = 32'h0000_BEEF;
    for (int unsigned n = 0; n <= 6; n++) begin
      bus.start  = (n == 0);
      bus.hiwe   = (n == 3);
      bus.cancel = (n == 6);
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.hiwe   = 1'b0;
    bus.cancel = 1'b0;
    check("hiwe while busy ignored", bus.hi, 32'h0000_AAAA);
    check("busy after cancel", 32'(bus.busy), 32'd0);

    // Cancel sequence with HI/LO = 0x11/0x22
    bus.hiwe = 1'b1;
    bus.lowe = 1'b1;
    bus.wd   = 32'h11;
    @(negedge clk);
    bus.lowe = 1'b1;
    bus.hiwe = 1'b0;
    bus.wd   = 32'h22;
    @(negedge clk);
    bus.lowe = 1'b0;
    check("preset hi", bus.hi, 32'h11);
    check("preset lo", bus.lo, 32'h22);
    bus.op   = DIVU;
    bus.srca = 32'd100;
    bus.srcb = 32'd7;
    for (int unsigned n = 0; n <= 10; n++) begin
      bus.start  = (n == 0 || n == 5);
      bus.cancel = (n == 10);
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel busy", 32'(bus.busy), 32'd0);
    check("cancel done", 32'(bus.done), 32'd0);
    seen = 0;
    for (int unsigned n = 0; n < 40; n++) begin
      if (bus.done || bus.busy) seen++;
      @(negedge clk);
    end
    check("no activity after cancel", 32'(seen), 32'd0);
    check("cancel hi kept", bus.hi, 32'h11);
    check("cancel lo kept", bus.lo, 32'h22);

    // start and cancel together in IDLE: nothing launches
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start+cancel idle busy", 32'(bus.busy), 32'd0);

    // start with MTHI/MTLO together: write lands, op still launches
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.srca  = 32'd6;
    bus.srcb  = 32'd7;
    bus.hiwe  = 1'b1;
    bus.lowe  = 1'b1;
    bus.wd    = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hiwe  = 1'b0;
    bus.lowe  = 1'b0;
    check("start+mthi hi", bus.hi, 32'h5555);
    check("start+mtlo lo", bus.lo, 32'h5555);
    check("start+mthi busy", 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("start+mthi latency", 32'(lat), 32'd34);
    check("start+mthi result hi", bus.hi, 32'd0);
    check("start+mthi result lo", bus.lo, 32'd42);

    // Fixed vectors, issued back-to-back
    for (int unsigned i = 0; i < 10; i++) begin
      doOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCnt);
      check({vecs[i].name, " hi"}, bus.hi, vecs[i].expHi);
      check({vecs[i].name, " lo"}, bus.lo, vecs[i].expLo);
      check({vecs[i].name, " latency"}, 32'(lat), 32'd34);
      check({vecs[i].name, " busy cycles"}, 32'(busyCnt), 32'd33);
      check({vecs[i].name, " busy at done"}, 32'(bus.busy), 32'd0);
    end

    // Reset mid-CALC
    bus.op   = MULT;
    bus.srca = 32'h1234_5678;
    bus.srcb = 32'h9ABC_DEF0;
    for (int unsigned n = 0; n <= 10; n++) begin
      bus.start = (n == 0);
      reset     = (n == 10);
      @(negedge clk);
    end
    reset = 1'b0;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset hi", bus.hi, 32'd0);
    check("mid reset lo", bus.lo, 32'd0);
    seen = 0;
    for (int unsigned n = 0; n < 40; n++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    check("no done after reset", 32'(seen), 32'd0);

    // Random operations against the reference model
    for (int unsigned i = 0; i < 300; i++) begin
      rop = op_t'($urandom_range(0, 3));
      ra  = randOperand();
      rb  = randOperand();
      refModel(rop, ra, rb, eh, el);
      doOp(rop, ra, rb, lat, busyCnt);
      check($sformatf("rand %0d op%0d %h,%h hi", i, rop, ra, rb), bus.hi, eh);
      check($sformatf("rand %0d op%0d %h,%h lo", i, rop, ra, rb), bus.lo, el);
      check($sformatf("rand %0d latency", i), 32'(lat), 32'd34);
    end

    @(negedge clk);
    check("final done pulse cleared", 32'(bus.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
